// File: rtl/control_pipeline_pkg.sv
// Shared decode/pipeline definitions: ALU operation classes, FSM states and
// the per-stage control bundles carried down the pipeline.
package control_pipeline_pkg;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_FUNCT  = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } state_e;

    typedef struct packed {
        logic    halt;
        logic    mem_read;
        logic    mem_to_reg;
        logic    mem_write;
        logic    alu_src;
        logic    reg_write;
        alu_op_e alu_op;
    } idex_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
    } exmem_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } memwb_t;

endpackage

// File: rtl/control_pipeline_ctrl_stage_reg.sv
// One pipeline control register; reset or a bubble request loads all-zero
// control, otherwise the next-stage bundle is captured every edge.
module ctrl_stage_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_bubble,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset || i_bubble) begin
            r_q <= '0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/control_pipeline.sv
// ID/EX -> EX/MEM -> MEM/WB control pipeline with an ECALL-driven halt:
// a halting ECALL stops issue, waits DRAIN_CYCLES for older work, then halts.
module control_pipeline
    import control_pipeline_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_mem_read,
    input  logic       id_mem_to_reg,
    input  logic       id_mem_write,
    input  logic       id_alu_src,
    input  logic       id_reg_write,
    input  logic [1:0] id_alu_op,
    input  logic       id_is_ecall,
    input  logic       id_halt_req,
    input  logic       flush_ex,
    output logic       ex_alu_src,
    output logic [1:0] ex_alu_op,
    output logic       ex_mem_read,
    output logic       ex_reg_write,
    output logic       mem_mem_read,
    output logic       mem_mem_write,
    output logic       mem_reg_write,
    output logic       mem_mem_to_reg,
    output logic       wb_mem_to_reg,
    output logic       wb_reg_write,
    output logic       is_halted
);

    localparam int CW = $clog2(DRAIN_CYCLES + 1);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            r_is_halted;

    idex_t           w_idex_d;
    idex_t           r_idex;
    exmem_t          w_exmem_d;
    exmem_t          r_exmem;
    memwb_t          w_memwb_d;
    memwb_t          r_memwb;
    logic            w_idex_bubble;

    // ECALLs never write the register file, halting or not.
    always_comb begin
        w_idex_d.halt       = id_is_ecall & id_halt_req;
        w_idex_d.mem_read   = id_mem_read;
        w_idex_d.mem_to_reg = id_mem_to_reg;
        w_idex_d.mem_write  = id_mem_write;
        w_idex_d.alu_src    = id_alu_src;
        w_idex_d.reg_write  = id_reg_write & ~id_is_ecall;
        w_idex_d.alu_op     = alu_op_e'(id_alu_op);
    end

    assign w_idex_bubble = flush_ex | (r_state != ST_RUN) | r_idex.halt;

    always_comb begin
        w_exmem_d.mem_read   = r_idex.mem_read;
        w_exmem_d.mem_write  = r_idex.mem_write;
        w_exmem_d.reg_write  = r_idex.reg_write;
        w_exmem_d.mem_to_reg = r_idex.mem_to_reg;
        w_memwb_d.mem_to_reg = r_exmem.mem_to_reg;
        w_memwb_d.reg_write  = r_exmem.reg_write;
    end

    ctrl_stage_reg #(.WIDTH($bits(idex_t))) u_idex (
        .clk      (clk),
        .reset    (reset),
        .i_bubble (w_idex_bubble),
        .i_d      (w_idex_d),
        .o_q      (r_idex)
    );

    ctrl_stage_reg #(.WIDTH($bits(exmem_t))) u_exmem (
        .clk      (clk),
        .reset    (reset),
        .i_bubble (1'b0),
        .i_d      (w_exmem_d),
        .o_q      (r_exmem)
    );

    ctrl_stage_reg #(.WIDTH($bits(memwb_t))) u_memwb (
        .clk      (clk),
        .reset    (reset),
        .i_bubble (1'b0),
        .i_d      (w_memwb_d),
        .o_q      (r_memwb)
    );

    // Halt sequencing: counter only moves in DRAIN and stops at zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_RUN: begin
                if (r_idex.halt) begin
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = CW'(DRAIN_CYCLES);
                end
            end
            ST_DRAIN: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = ST_HALTED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - CW'(1);
                end
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_cnt       <= '0;
            r_is_halted <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_is_halted <= (w_state_nxt == ST_HALTED);
        end
    end

    assign ex_alu_src     = r_idex.alu_src;
    assign ex_alu_op      = r_idex.alu_op;
    assign ex_mem_read    = r_idex.mem_read;
    assign ex_reg_write   = r_idex.reg_write;
    assign mem_mem_read   = r_exmem.mem_read;
    assign mem_mem_write  = r_exmem.mem_write;
    assign mem_reg_write  = r_exmem.reg_write;
    assign mem_mem_to_reg = r_exmem.mem_to_reg;
    assign wb_mem_to_reg  = r_memwb.mem_to_reg;
    assign wb_reg_write   = r_memwb.reg_write;
    assign is_halted      = r_is_halted;

endmodule

// File: tb/tb_control_pipeline.sv
// Randomized and directed bench for control_pipeline against a delay-line
// reference model with an edge-count halt prediction.
module tb_control_pipeline;

    localparam int DC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write;
    logic [1:0] id_alu_op;
    logic       id_is_ecall, id_halt_req, flush_ex;
    logic       ex_alu_src;
    logic [1:0] ex_alu_op;
    logic       ex_mem_read, ex_reg_write;
    logic       mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg;
    logic       wb_mem_to_reg, wb_reg_write, is_halted;

    int checks   = 0;
    int failures = 0;

    // Model: entries {halt, mr, mtr, mw, as, rw, op[1:0]} delayed 1/2/3 edges.
    logic [7:0] h1, h2, h3;
    bit         latched;
    int         halt_edge;
    int         edge_n;

    control_pipeline #(.DRAIN_CYCLES(DC)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_mem_read    (id_mem_read),
        .id_mem_to_reg  (id_mem_to_reg),
        .id_mem_write   (id_mem_write),
        .id_alu_src     (id_alu_src),
        .id_reg_write   (id_reg_write),
        .id_alu_op      (id_alu_op),
        .id_is_ecall    (id_is_ecall),
        .id_halt_req    (id_halt_req),
        .flush_ex       (flush_ex),
        .ex_alu_src     (ex_alu_src),
        .ex_alu_op      (ex_alu_op),
        .ex_mem_read    (ex_mem_read),
        .ex_reg_write   (ex_reg_write),
        .mem_mem_read   (mem_mem_read),
        .mem_mem_write  (mem_mem_write),
        .mem_reg_write  (mem_reg_write),
        .mem_mem_to_reg (mem_mem_to_reg),
        .wb_mem_to_reg  (wb_mem_to_reg),
        .wb_reg_write   (wb_reg_write),
        .is_halted      (is_halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic set_in(input logic mr, mtr, mw, as, rw, input logic [1:0] op,
                          input logic ec, hr, fl);
        id_mem_read   = mr;
        id_mem_to_reg = mtr;
        id_mem_write  = mw;
        id_alu_src    = as;
        id_reg_write  = rw;
        id_alu_op     = op;
        id_is_ecall   = ec;
        id_halt_req   = hr;
        flush_ex      = fl;
    endtask

    task automatic nop();   set_in(0,0,0,0,0,2'b00,0,0,0); endtask
    task automatic add_i(); set_in(0,0,0,0,1,2'b00,0,0,0); endtask

    task automatic model_update();
        logic [7:0] e;
        edge_n++;
        if (reset) begin
            h1 = '0; h2 = '0; h3 = '0;
            latched   = 0;
            halt_edge = -1;
        end else begin
            if (flush_ex || latched)
                e = '0;
            else
                e = {id_is_ecall & id_halt_req, id_mem_read, id_mem_to_reg, id_mem_write,
                     id_alu_src, id_reg_write & ~id_is_ecall, id_alu_op};
            h3 = h2; h2 = h1; h1 = e;
            if (e[7]) begin
                latched   = 1;
                halt_edge = edge_n + DC + 1;
            end
        end
    endtask

    task automatic compare_all();
        logic exp_h;
        exp_h = (halt_edge >= 0) && (edge_n >= halt_edge);
        chk("ex_alu_src",     {1'b0, ex_alu_src},     {1'b0, h1[3]});
        chk("ex_alu_op",      ex_alu_op,              h1[1:0]);
        chk("ex_mem_read",    {1'b0, ex_mem_read},    {1'b0, h1[6]});
        chk("ex_reg_write",   {1'b0, ex_reg_write},   {1'b0, h1[2]});
        chk("mem_mem_read",   {1'b0, mem_mem_read},   {1'b0, h2[6]});
        chk("mem_mem_write",  {1'b0, mem_mem_write},  {1'b0, h2[4]});
        chk("mem_reg_write",  {1'b0, mem_reg_write},  {1'b0, h2[2]});
        chk("mem_mem_to_reg", {1'b0, mem_mem_to_reg}, {1'b0, h2[5]});
        chk("wb_mem_to_reg",  {1'b0, wb_mem_to_reg},  {1'b0, h3[5]});
        chk("wb_reg_write",   {1'b0, wb_reg_write},   {1'b0, h3[2]});
        chk("is_halted",      {1'b0, is_halted},      {1'b0, exp_h});
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        nop();
        step();
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        logic [10:0] v;
        v = {ex_alu_src, ex_alu_op, ex_mem_read, ex_reg_write, mem_mem_read, mem_mem_write,
             mem_reg_write, mem_mem_to_reg, wb_mem_to_reg, wb_reg_write};
        chk(tag, {1'b0, |v}, 2'b00);
    endtask

    initial begin
        h1 = '0; h2 = '0; h3 = '0;
        latched = 0; halt_edge = -1; edge_n = 0;
        reset = 1'b1;
        nop();
        step();
        step();
        reset = 1'b0;
        chk_all_zero("reset_outputs");
        chk("reset_halted", {1'b0, is_halted}, 2'b00);

        // Load flows ID/EX -> EX/MEM -> MEM/WB.
        set_in(1,1,0,1,1,2'b00,0,0,0);
        step();
        chk("load_ex_mem_read", {1'b0, ex_mem_read}, 2'b01);
        nop();
        step();
        chk("load_mem_mem_read", {1'b0, mem_mem_read}, 2'b01);
        step();
        chk("load_wb_mem_to_reg", {1'b0, wb_mem_to_reg}, 2'b01);
        step();
        chk_all_zero("load_drained");

        // Flushed store never reaches memory.
        set_in(0,0,1,1,0,2'b00,0,0,1);
        step();
        chk("flush_ex_zero", {1'b0, ex_alu_src | ex_mem_read | ex_reg_write | (|ex_alu_op)}, 2'b00);
        nop();
        for (int i = 0; i < 2; i++) begin
            step();
            chk("flush_mem_write", {1'b0, mem_mem_write}, 2'b00);
        end

        // Halting ECALL followed by ADDs.
        do_reset();
        set_in(0,0,0,0,0,2'b00,1,1,0);
        step();
        add_i();
        step();
        chk("halt_e1_ex_rw", {1'b0, ex_reg_write}, 2'b00);
        step();
        chk("halt_e2_ex_rw", {1'b0, ex_reg_write}, 2'b00);
        chk("halt_e2_halted", {1'b0, is_halted}, 2'b00);
        step();
        chk("halt_e3_halted", {1'b0, is_halted}, 2'b01);
        for (int i = 0; i < 4; i++) step();
        chk("halt_sticky", {1'b0, is_halted}, 2'b01);
        chk("halt_ex_rw_late", {1'b0, ex_reg_write}, 2'b00);

        // Non-halting ECALL leaves the FSM alone.
        do_reset();
        set_in(0,0,0,0,0,2'b00,1,0,0);
        step();
        add_i();
        for (int i = 0; i < 10; i++) step();
        chk("nohalt_halted", {1'b0, is_halted}, 2'b00);
        chk("nohalt_ex_rw", {1'b0, ex_reg_write}, 2'b01);
        chk("nohalt_wb_rw", {1'b0, wb_reg_write}, 2'b01);

        // Reset one edge into DRAIN recovers a running pipeline.
        do_reset();
        set_in(0,0,0,0,0,2'b00,1,1,0);
        step();
        add_i();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("drain_rst_halted", {1'b0, is_halted}, 2'b00);
        chk_all_zero("drain_rst_zero");
        step();
        chk("drain_rst_add", {1'b0, ex_reg_write}, 2'b01);
        for (int i = 0; i < 5; i++) step();
        chk("drain_rst_no_halt", {1'b0, is_halted}, 2'b00);

        // Flush beats a halting ECALL.
        do_reset();
        set_in(0,0,0,0,0,2'b00,1,1,1);
        step();
        add_i();
        for (int i = 0; i < 10; i++) step();
        chk("flush_halt_none", {1'b0, is_halted}, 2'b00);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 600; i++) begin
            set_in(1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
                   1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 2'($urandom_range(0,2)),
                   1'($urandom_range(0,11) == 0), 1'($urandom_range(0,1)),
                   1'($urandom_range(0,6) == 0));
            reset = ($urandom_range(0,39) == 0);
            step();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_pipeline.md
CONTROL_PIPELINE -- requirements
Module: control_pipeline

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 2, giving the cycles from leaving RUN to HALTED, which must cover older instructions finishing MEM and WB.
REQ-002 SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write  in  1 each  ID-stage decoded control bits.
REQ-006 id_alu_op  in  2  ID-stage ALU operation class (00 add, 01 branch compare, 10 funct-decoded).
REQ-007 id_is_ecall  in  1  ID instruction is ECALL.
REQ-008 id_halt_req  in  1  x17 equals 10 at ID (forwarded value); meaningful only with id_is_ecall.
REQ-009 flush_ex  in  1  discard the ID instruction entering ID/EX (taken branch / mispredict).
REQ-010 ex_alu_src  out  1; ex_alu_op  out  2; ex_mem_read  out  1 (load-use detection); ex_reg_write  out  1.
REQ-011 mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg  out  1 each  EX/MEM control.
REQ-012 wb_mem_to_reg, wb_reg_write  out  1 each  MEM/WB control.
REQ-013 is_halted  out  1  high once the halting ECALL has drained; stays high until reset.

Function
REQ-014 SHALL hold three registered stages, ID/EX, EX/MEM and MEM/WB, each advancing every clock with no stall input; a bubble is all-zero control.
REQ-015 ID/EX SHALL load a bubble when flush_ex=1, when the FSM is not RUN, or when ID/EX currently holds a halting ECALL; otherwise it loads the id_* inputs.
REQ-016 A halting ECALL SHALL be id_is_ecall=1 and id_halt_req=1 sampled at the ID/EX load; it is stored as one flag bit with the entry.
REQ-017 flush_ex and a halting ECALL in the same cycle: flush SHALL win, no flag is latched, and the FSM stays in RUN.
REQ-018 A non-halting ECALL (id_halt_req=0) SHALL propagate with reg_write=0 and SHALL NOT affect the FSM.
REQ-019 EX/MEM SHALL copy mem_read, mem_write, reg_write and mem_to_reg from ID/EX; MEM/WB SHALL copy mem_to_reg and reg_write from EX/MEM; the EX-only bits are dropped.
REQ-020 FSM states are RUN, DRAIN and HALTED; the encoding is free.
REQ-021 RUN to DRAIN SHALL happen at the first edge where ID/EX holds the halting flag; the down-counter loads DRAIN_CYCLES.
REQ-022 In DRAIN the counter SHALL decrement each edge; at the edge where the counter equals 1, the FSM enters HALTED.
REQ-023 HALTED is terminal; is_halted SHALL be 1 exactly when state is HALTED, as a registered output.
REQ-024 With default DRAIN_CYCLES, an ECALL latched into ID/EX at edge E0 SHALL produce is_halted=1 after edge E3.
REQ-025 The counter SHALL be ceil(log2(DRAIN_CYCLES+1)) bits wide and SHALL never wrap; DRAIN_CYCLES=1 goes DRAIN to HALTED on the next edge.
REQ-026 No combinational path SHALL exist from any input to any output.

Reset
REQ-027 On reset=1 at an edge, all stage registers SHALL clear to bubble, the halting flag SHALL clear, the FSM SHALL return to RUN, the counter SHALL clear, and is_halted SHALL be 0.
REQ-028 Reset SHALL take priority over flush, load and FSM advance, including mid-DRAIN and in HALTED.

Structure
REQ-029 The ALU_OP encodings (00/01/10) and the FSM state constants SHALL live in the shared opcodes/defines include used by the decoder.
REQ-030 A sub-module ctrl_stage_reg (width-parameterised register with synchronous reset and bubble-load) SHALL be instantiated once per stage.

Verification
REQ-031 Load decode (read=1, to_reg=1, reg_write=1, alu_src=1) at E0 -> ex_mem_read=1 after E0, mem_mem_read=1 after E1, wb_mem_to_reg=1 after E2, then all zero.
REQ-032 Store with flush_ex=1 at E0 -> ex_* all 0 after E0 and mem_mem_write stays 0 through E2.
REQ-033 Halting ECALL at E0, followed by reg_write=1 ADDs every cycle -> ex_reg_write=0 from E1 onward, is_halted=0 after E2, and is_halted=1 after E3 and thereafter.
REQ-034 ECALL with id_halt_req=0 -> is_halted stays 0 for 10 cycles and following ADDs propagate normally.
REQ-035 Reset asserted one edge after entering DRAIN -> is_halted=0, all outputs 0, and a new ADD at the next edge reaches ex_reg_write=1.
REQ-036 Halting ECALL and flush_ex both high at E0 -> no halt for 10 cycles.
